// File: rtl/cti8_irq_pkg.sv
// cti8_irq_pkg: shared state encoding and register map for the interrupt controller
package cti8_irq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} state_t;
  localparam logic [1:0] A_MASK  = 2'd0;
  localparam logic [1:0] A_PEND  = 2'd1;
  localparam logic [1:0] A_VBASE = 2'd2;
  localparam logic [1:0] A_EOI   = 2'd3;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] active,
  output logic         any,
  output logic [2:0]   idx
);
  always_comb begin
    any = |active;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (active[i]) idx = 3'(i);
  end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked, fixed-priority interrupt controller with inta/EOI handshake
module irq_controller
  import cti8_irq_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic             wr,
  input  logic             rd,
  input  logic [1:0]       addr,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  input  logic             inta,
  output logic             INT,
  output logic [DW-1:0]    vector
);
  logic [N_SRC-1:0] mask, pend, irq_q, active, w1c, ack_clr, pend_n;
  logic [DW-1:0] vbase;
  logic [2:0] isr_idx, idx;
  logic any, ack, eoi;
  state_t state, state_n;
  assign active = pend & mask;
  irq_prio_enc #(.N(N_SRC)) u_prio (.active(active), .any(any), .idx(idx));
  assign ack = inta && state == ASSERT && any;
  assign eoi = wr && addr == A_EOI;
  assign w1c = (wr && addr == A_PEND) ? din[N_SRC-1:0] : '0;
  assign ack_clr = ack ? N_SRC'(1) << idx : '0;
  assign pend_n = (pend & ~w1c & ~ack_clr) | (irq & ~irq_q);
  always_comb begin
    state_n = state == IDLE   ? (any ? ASSERT : IDLE) :
              state == ASSERT ? (ack ? SERVICE : any ? ASSERT : IDLE) :
              (eoi ? IDLE : SERVICE);
  end
  always_comb begin
    dout = !rd              ? '0 :
           addr == A_MASK   ? DW'(mask) :
           addr == A_PEND   ? DW'(pend) :
           addr == A_VBASE  ? vbase :
           {state, {(DW-5){1'b0}}, isr_idx};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mask    <= '0;
      pend    <= '0;
      vbase   <= '0;
      irq_q   <= '0;
      INT     <= 1'b0;
      vector  <= '0;
      isr_idx <= '0;
      state   <= IDLE;
    end else begin
      irq_q <= irq;
      pend  <= pend_n;
      state <= state_n;
      INT   <= state_n == ASSERT;
      if (wr && addr == A_MASK) mask <= din[N_SRC-1:0];
      if (wr && addr == A_VBASE) vbase <= din;
      if (ack) begin
        vector  <= vbase + DW'(idx);
        isr_idx <= idx;
      end else if (inta && state != ASSERT) vector <= vbase + DW'(N_SRC);
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed literal checks plus randomized run against a behavioural model
module tb_irq_controller;
  logic clk = 0, reset = 1, wr = 0, rd = 0, inta = 0;
  logic [3:0] irq = 0;
  logic [1:0] addr = 0;
  logic [7:0] din = 0;
  logic [7:0] dout, vector;
  logic INT;
  int checks = 0, errors = 0;
  bit live = 0;
  int m_mask, m_pend, m_vbase, m_irq_q, m_vec, m_isr, m_st;
  irq_controller #(.N_SRC(4), .DW(8)) dut (
    .clk(clk), .reset(reset), .irq(irq), .wr(wr), .rd(rd), .addr(addr),
    .din(din), .dout(dout), .inta(inta), .INT(INT), .vector(vector)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic int lowest(input int v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction
  always @(posedge clk) begin : model
    int w, p, st;
    if (reset) begin
      m_mask = 0; m_pend = 0; m_vbase = 0; m_irq_q = 0; m_vec = 0; m_isr = 0; m_st = 0;
      live = 1;
    end else begin
      w = lowest(m_pend & m_mask);
      p = m_pend;
      if (wr && addr == 1) p = p & ~int'(din[3:0]);
      if (inta && m_st == 1 && w >= 0) begin
        m_vec = (m_vbase + w) % 256;
        m_isr = w;
        p = p & ~(1 << w);
      end else if (inta && m_st != 1) m_vec = (m_vbase + 4) % 256;
      p = p | (int'(irq) & ~m_irq_q);
      if (m_st == 0) st = (w >= 0) ? 1 : 0;
      else if (m_st == 1) st = (w < 0) ? 0 : inta ? 2 : 1;
      else st = (wr && addr == 3) ? 0 : 2;
      if (wr && addr == 0) m_mask = int'(din[3:0]);
      if (wr && addr == 2) m_vbase = int'(din);
      m_pend = p;
      m_st = st;
      m_irq_q = int'(irq);
    end
  end
  always @(negedge clk) begin
    if (live) begin
      chk("int", INT, m_st == 1);
      chk("vector", vector, m_vec);
      chk("dout", dout, !rd ? 0 : addr == 0 ? m_mask : addr == 1 ? m_pend :
                        addr == 2 ? m_vbase : (m_st << 6) | m_isr);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    wr = 0;
    rd = 0;
    inta = 0;
  endtask
  task automatic wreg(input logic [1:0] a, input logic [7:0] d);
    wr = 1;
    addr = a;
    din = d;
    tick();
  endtask
  task automatic do_ack();
    inta = 1;
    tick();
  endtask
  task automatic rreg(input logic [1:0] a, input logic [7:0] e, input string n);
    rd = 1;
    addr = a;
    #1;
    chk(n, dout, e);
    rd = 0;
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst_int", INT, 0);
    chk("rst_vec", vector, 0);
    wreg(0, 8'h0F);
    wreg(2, 8'h40);
    irq = 4'b0100;
    tick();
    chk("t1_int_early", INT, 0);
    irq = 0;
    tick();
    chk("t1_int", INT, 1);
    do_ack();
    chk("t1_vec", vector, 8'h42);
    chk("t1_int_ack", INT, 0);
    rreg(1, 8'h00, "t1_pend");
    rreg(3, 8'h82, "t1_svc");
    wreg(3, 8'h00);
    rreg(3, 8'h02, "t1_eoi");
    irq = 4'b1010;
    tick();
    irq = 0;
    tick();
    chk("t2_int", INT, 1);
    do_ack();
    chk("t2_vec1", vector, 8'h41);
    wreg(3, 8'h00);
    tick();
    chk("t2_reint", INT, 1);
    do_ack();
    chk("t2_vec2", vector, 8'h43);
    wreg(3, 8'h00);
    wreg(0, 8'h00);
    irq = 4'b0001;
    tick();
    irq = 0;
    tick();
    rreg(1, 8'h01, "t3_pend");
    chk("t3_masked", INT, 0);
    wreg(0, 8'h01);
    chk("t3_int_wait", INT, 0);
    tick();
    chk("t3_int", INT, 1);
    wreg(1, 8'h01);
    chk("t4_int_hold", INT, 1);
    tick();
    chk("t4_int_drop", INT, 0);
    rreg(3, 8'h03, "t4_idle");
    do_ack();
    chk("t4_spur_vec", vector, 8'h44);
    rreg(3, 8'h03, "t4_spur_state");
    wreg(0, 8'h0F);
    irq = 4'b0010;
    tick();
    irq = 0;
    tick();
    chk("t5_int", INT, 1);
    do_ack();
    chk("t5_vec", vector, 8'h41);
    irq = 4'b0001;
    tick();
    irq = 0;
    tick();
    rreg(1, 8'h01, "t5_pend");
    chk("t5_int_svc", INT, 0);
    wreg(3, 8'h00);
    chk("t5_int_eoi", INT, 0);
    tick();
    chk("t5_int_re", INT, 1);
    reset = 1;
    tick();
    chk("t6_int", INT, 0);
    chk("t6_vec", vector, 0);
    rreg(1, 8'h00, "t6_pend");
    rreg(0, 8'h00, "t6_mask");
    reset = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) irq = 4'($urandom);
      wr = ($urandom_range(0, 5) == 0);
      addr = 2'($urandom);
      din = 8'($urandom);
      inta = ($urandom_range(0, 3) == 0);
      rd = 1'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    reset = 0;
    wr = 0;
    inta = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
